motor_bi_decoder: RTL and testbench
===================================

Name: motor_bi_decoder

Overview:
- Observes the 4-bit bipolar coil drive pattern produced by the stepper driver and recovers position index, direction, signed step count and step period.
- Flags illegal patterns and skipped steps.
- Sits beside the motor driver as a closed-loop monitor/verifier, or on the input pins when decoding an external drive.
- The coil input is asynchronous to clk and is synchronised and glitch-filtered internally.

Parameters:
- FILT_CYCLES, 4, consecutive synchronised cycles a pattern must be stable before it is accepted (legal 1..255).
- STALL_CYCLES, 24'd5_000_000, cycles without an accepted step before stalled asserts.
- CNT_W, 16, width of the signed step counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- coil_in  in  4  coil pattern from the driver (asynchronous)
- clr  in  1  synchronous clear of count, fault, period and state
- pos_idx  out  2  current position: 0=0110, 1=0101, 2=1001, 3=1010
- dir  out  1  1 = last step forward (idx+1 mod 4), 0 = reverse
- step_stb  out  1  one-cycle pulse per accepted step
- step_count  out  CNT_W  signed two's-complement step count
- period  out  24  clk cycles between the last two accepted steps
- period_vld  out  1  one-cycle pulse when period updates
- stalled  out  1  no step for STALL_CYCLES cycles
- fault  out  1  sticky error flag
- err_code  out  2  00 none, 01 invalid pattern, 10 skipped step; first error only

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; synchroniser flops, filter, timers 0; state ACQUIRE.
- Synchroniser: two flops on coil_in; filtering uses the second-flop output (s).
- Filter:
  - Candidate register plus stability counter.
  - When s differs from the candidate, load the candidate and reset the counter to 1.
  - When s equals the candidate, increment, saturating at FILT_CYCLES.
  - A pattern is "accepted" on the cycle the counter reaches FILT_CYCLES and the candidate differs from the last accepted pattern. Exactly one accept event per new pattern.
- Latency: coil_in change → step_stb = 2 + FILT_CYCLES clk cycles (6 at default). Glitches shorter than FILT_CYCLES cycles produce no event.
- Pattern 0000 (de-energised) on accept: ignored. No step, no fault, last accepted pattern retained.
- Pattern classes: legal = 0110/0101/1001/1010; any other nonzero value = invalid.
- State machine:
  - ACQUIRE:
    - Accepted legal pattern: set pos_idx, go to TRACK. No step_stb, count unchanged, period timer cleared.
    - Accepted invalid pattern: go to FAULT, err_code=01.
  - TRACK, on accepted legal pattern with delta d = (new − pos_idx) mod 4:
    - d=1: dir=1, count+1, step_stb.
    - d=3: dir=0, count−1, step_stb.
    - d=2: go to FAULT, err_code=10. pos_idx updated to new pattern, count unchanged.
  - TRACK, accepted invalid pattern: go to FAULT, err_code=01.
  - FAULT: fault=1. pos_idx keeps tracking legal patterns silently (no strobe, no count). Exit only via clr or reset.
- Count wraps two's-complement: 0x7FFF+1 = 0x8000, 0x0000−1 = 0xFFFF. No saturation.
- Period timer:
  - Counts every cycle in TRACK, saturating at 0xFFFFFF.
  - On each step_stb: period ← timer, timer ← 1, period_vld pulses in the same cycle as step_stb.
  - The first step after ACQUIRE does pulse period_vld (its timer started at acquisition).
- stalled: set when timer ≥ STALL_CYCLES in TRACK; cleared on the cycle step_stb asserts, or on clr.
- clr (synchronous):
  - Zeroes step_count, period, fault, err_code, stalled and the timer; state → ACQUIRE. pos_idx and dir hold.
  - clr wins over a simultaneous accept: that event is discarded, and the pattern is re-acquired only when a new pattern is accepted.
- Reset asserted mid-step: outputs drop immediately. After release, decoding restarts from ACQUIRE with the synchroniser flushed.

Test Plan:
- Forward drive 0110→0101→1001→1010→0110, each held 20 cycles, FILT=4 → acquire at idx0, 4 step_stb, step_count=4, dir=1, period=20 on the last three strobes, step_stb exactly 6 cycles after each change.
- Reverse from idx0: 1010, 1001 → step_count=−2 (0xFFFE), dir=0. Then 1-cycle and 3-cycle glitches to 0101 → no strobe, count unchanged.
- Skip 0110→1001 in TRACK → fault=1, err_code=10, no step_stb. A following invalid 1111 keeps err_code=10. clr → fault=0, count=0, ACQUIRE.
- Invalid 0111 held ≥ FILT_CYCLES after acquire → fault=1, err_code=01. Pattern 0000 inserted between legal steps → no fault, step continues from the prior index.
- STALL_CYCLES=100: hold one pattern 150 cycles → stalled=1 from cycle 100 after the last step; next step clears it, period=150 (clamped check with 0xFFFFFF run optional).
- Preload count to 0x7FFF via forward steps (CNT_W=16) and step +1 → 0x8000. Assert rst_n=0 mid-filter → all outputs 0 asynchronously, no strobe after release until re-acquire.

Source files
------------

// File: rtl/motor_bi_decoder.sv
// Bipolar stepper coil-pattern decoder: recovers position, direction, signed step
// count and step period from the 4-bit drive pattern, and flags illegal patterns and skips.
module motor_bi_decoder #(
    parameter int unsigned FILT_CYCLES  = 4,
    parameter logic [23:0] STALL_CYCLES = 24'd5_000_000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       coil_in,
    input  logic             clr,
    output logic [1:0]       pos_idx,
    output logic             dir,
    output logic             step_stb,
    output logic [CNT_W-1:0] step_count,
    output logic [23:0]      period,
    output logic             period_vld,
    output logic             stalled,
    output logic             fault,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [1:0]       ERR_NONE    = 2'b00;
    localparam logic [1:0]       ERR_INVALID = 2'b01;
    localparam logic [1:0]       ERR_SKIP    = 2'b10;
    localparam logic [7:0]       FILT_MAX    = 8'(FILT_CYCLES);
    localparam logic [23:0]      TIMER_MAX   = 24'hFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Returns {legal, index} for a coil pattern.
    function automatic logic [2:0] decode_pat(input logic [3:0] p);
        case (p)
            4'b0110: decode_pat = 3'b1_00;
            4'b0101: decode_pat = 3'b1_01;
            4'b1001: decode_pat = 3'b1_10;
            4'b1010: decode_pat = 3'b1_11;
            default: decode_pat = 3'b0_00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and glitch filter
    // ------------------------------------------------------------------
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cand_q, last_q;
    logic [7:0] cnt_q;
    logic       reach;
    logic       accept;
    logic       new_evt;
    logic       pat_legal;
    logic [1:0] pat_idx;

    // NOTE: non-blocking assignments keep the two flops a real two-stage shift;
    // blocking ones here would collapse the synchroniser into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= coil_in;
            sync2_q <= sync1_q;
        end
    end

    // The candidate always becomes sync2_q next cycle, so the accepted pattern is sync2_q.
    always_comb begin
        reach = 1'b0;
        if (sync2_q != cand_q)
            reach = (FILT_MAX == 8'd1);
        else
            reach = (cnt_q != FILT_MAX) && ((cnt_q + 8'd1) == FILT_MAX);
    end

    assign accept  = reach && (sync2_q != last_q);
    assign new_evt = accept && (sync2_q != 4'b0000);
    assign {pat_legal, pat_idx} = decode_pat(sync2_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= 4'b0000;
            cnt_q  <= 8'd0;
            last_q <= 4'b0000;
        end else begin
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= 8'd1;
            end else if (cnt_q != FILT_MAX) begin
                cnt_q  <= cnt_q + 8'd1;
            end
            // De-energised 0000 never replaces the reference pattern.
            if (new_evt)
                last_q <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // Decode state machine
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       pos_d;
    logic             dir_d;
    logic [CNT_W-1:0] count_d;
    logic [1:0]       err_d;
    logic             stb_d;
    logic             acquire;
    logic [1:0]       delta;

    assign delta = pat_idx - pos_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_ACQUIRE;
        else
            state_q <= state_d;
    end

    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_idx;
        dir_d   = dir;
        count_d = step_count;
        err_d   = err_code;
        stb_d   = 1'b0;
        acquire = 1'b0;
        if (clr) begin
            state_d = ST_ACQUIRE;
            count_d = '0;
            err_d   = ERR_NONE;
        end else if (new_evt) begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (pat_legal) begin
                        pos_d   = pat_idx;
                        state_d = ST_TRACK;
                        acquire = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        err_d   = ERR_INVALID;
                    end
                end
                ST_TRACK: begin
                    if (!pat_legal) begin
                        state_d = ST_FAULT;
                        err_d   = ERR_INVALID;
                    end else begin
                        pos_d = pat_idx;
                        case (delta)
                            2'd1: begin
                                dir_d   = 1'b1;
                                count_d = step_count + CNT_ONE;
                                stb_d   = 1'b1;
                            end
                            2'd3: begin
                                dir_d   = 1'b0;
                                count_d = step_count - CNT_ONE;
                                stb_d   = 1'b1;
                            end
                            2'd2: begin
                                state_d = ST_FAULT;
                                err_d   = ERR_SKIP;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_FAULT: begin
                    // Position keeps following the drive; the first error code sticks.
                    if (pat_legal)
                        pos_d = pat_idx;
                end
                default: state_d = ST_ACQUIRE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Period timer and stall detection
    // ------------------------------------------------------------------
    logic [23:0] timer_q, timer_d;
    logic [23:0] period_d;
    logic        pvld_d;
    logic        stall_d;

    always_comb begin
        timer_d  = timer_q;
        period_d = period;
        pvld_d   = 1'b0;
        stall_d  = stalled;
        if (clr) begin
            timer_d  = 24'd0;
            period_d = 24'd0;
            stall_d  = 1'b0;
        end else if (stb_d) begin
            period_d = timer_q;
            timer_d  = 24'd1;
            pvld_d   = 1'b1;
            stall_d  = 1'b0;
        end else if (acquire) begin
            timer_d = 24'd0;
        end else if (state_q == ST_TRACK) begin
            if (timer_q != TIMER_MAX)
                timer_d = timer_q + 24'd1;
            if (timer_q >= STALL_CYCLES)
                stall_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_idx    <= 2'd0;
            dir        <= 1'b0;
            step_stb   <= 1'b0;
            step_count <= '0;
            period     <= 24'd0;
            period_vld <= 1'b0;
            stalled    <= 1'b0;
            fault      <= 1'b0;
            err_code   <= ERR_NONE;
            timer_q    <= 24'd0;
        end else begin
            pos_idx    <= pos_d;
            dir        <= dir_d;
            step_stb   <= stb_d;
            step_count <= count_d;
            period     <= period_d;
            period_vld <= pvld_d;
            stalled    <= stall_d;
            fault      <= (state_d == ST_FAULT);
            err_code   <= err_d;
            timer_q    <= timer_d;
        end
    end

endmodule

// File: tb/tb_motor_bi_decoder.sv
// Directed bench for motor_bi_decoder: main instance (FILT=4, STALL=100, 16-bit count)
// plus a narrow instance (FILT=1, 8-bit count) for counter wrap and minimum latency.
module tb_motor_bi_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        clr2 = 1'b0;
    logic [3:0]  coil = 4'b0000;
    logic [3:0]  coil2 = 4'b0000;

    logic [1:0]  pos_idx, pos2;
    logic        dir, dir2, step_stb, stb2, period_vld, pvld2, stalled, stalled2, fault, fault2;
    logic [15:0] step_count;
    logic [7:0]  count2;
    logic [23:0] period, period2;
    logic [1:0]  err_code, err2;

    int checks = 0;
    int errors = 0;
    int stb_cnt, stb_at, pvld_cnt;
    logic [23:0] per_at;
    int stb2_cnt, stb2_at;

    always #5 clk = ~clk;

    motor_bi_decoder #(.FILT_CYCLES(4), .STALL_CYCLES(24'd100), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .coil_in(coil), .clr(clr),
        .pos_idx(pos_idx), .dir(dir), .step_stb(step_stb), .step_count(step_count),
        .period(period), .period_vld(period_vld), .stalled(stalled),
        .fault(fault), .err_code(err_code)
    );

    motor_bi_decoder #(.FILT_CYCLES(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .coil_in(coil2), .clr(clr2),
        .pos_idx(pos2), .dir(dir2), .step_stb(stb2), .step_count(count2),
        .period(period2), .period_vld(pvld2), .stalled(stalled2),
        .fault(fault2), .err_code(err2)
    );

    // Apply a pattern at a falling edge and observe n falling edges.
    task automatic hold(input logic [3:0] p, input int n);
        coil = p; stb_cnt = 0; stb_at = 0; pvld_cnt = 0; per_at = 24'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (step_stb) begin stb_cnt++; if (stb_at == 0) stb_at = i; per_at = period; end
            if (period_vld) pvld_cnt++;
        end
    endtask

    task automatic hold2(input logic [3:0] p, input int n);
        coil2 = p; stb2_cnt = 0; stb2_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (stb2) begin stb2_cnt++; if (stb2_at == 0) stb2_at = i; end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (step_count !== 16'h0000) begin errors++; $display("FAIL rst_count: got %h expected 0000", step_count); end
        checks++; if (pos_idx !== 2'd0) begin errors++; $display("FAIL rst_pos: got %0d expected 0", pos_idx); end
        checks++; if ({dir, step_stb, period_vld, stalled, fault} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b expected 00000", {dir, step_stb, period_vld, stalled, fault}); end
        checks++; if (period !== 24'd0) begin errors++; $display("FAIL rst_period: got %0d expected 0", period); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", err_code); end
        checks++; if (count2 !== 8'h00) begin errors++; $display("FAIL rst_count2: got %h expected 00", count2); end
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'b0000, 10);
        checks++; if (stb_cnt !== 0 || fault !== 1'b0) begin errors++; $display("FAIL idle_zero: got stb=%0d fault=%b expected 0 0", stb_cnt, fault); end
    endtask

    task automatic test_forward();
        hold(4'b0110, 20);
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL fwd_acq_stb: got %0d expected 0", stb_cnt); end
        checks++; if (pos_idx !== 2'd0 || step_count !== 16'h0000) begin errors++; $display("FAIL fwd_acq: got pos=%0d count=%h expected 0 0000", pos_idx, step_count); end
        hold(4'b0101, 20);
        checks++; if (stb_cnt !== 1 || stb_at !== 6) begin errors++; $display("FAIL fwd1_latency: got cnt=%0d at=%0d expected 1 at 6", stb_cnt, stb_at); end
        checks++; if (pvld_cnt !== 1) begin errors++; $display("FAIL fwd1_pvld: got %0d expected 1", pvld_cnt); end
        checks++; if (pos_idx !== 2'd1 || dir !== 1'b1 || step_count !== 16'h0001) begin errors++; $display("FAIL fwd1_state: got pos=%0d dir=%b count=%h expected 1 1 0001", pos_idx, dir, step_count); end
        hold(4'b1001, 20);
        checks++; if (stb_at !== 6 || per_at !== 24'd20) begin errors++; $display("FAIL fwd2_period: got at=%0d period=%0d expected 6 20", stb_at, per_at); end
        checks++; if (pos_idx !== 2'd2 || step_count !== 16'h0002) begin errors++; $display("FAIL fwd2_state: got pos=%0d count=%h expected 2 0002", pos_idx, step_count); end
        hold(4'b1010, 20);
        checks++; if (stb_at !== 6 || per_at !== 24'd20) begin errors++; $display("FAIL fwd3_period: got at=%0d period=%0d expected 6 20", stb_at, per_at); end
        hold(4'b0110, 20);
        checks++; if (stb_at !== 6 || per_at !== 24'd20 || pvld_cnt !== 1) begin errors++; $display("FAIL fwd4_period: got at=%0d period=%0d pvld=%0d expected 6 20 1", stb_at, per_at, pvld_cnt); end
        checks++; if (pos_idx !== 2'd0 || dir !== 1'b1 || step_count !== 16'h0004) begin errors++; $display("FAIL fwd4_state: got pos=%0d dir=%b count=%h expected 0 1 0004", pos_idx, dir, step_count); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b expected 0", stalled); end
    endtask

    task automatic test_reverse();
        logic [3:0]  pats [6] = '{4'b1010, 4'b1001, 4'b0101, 4'b0110, 4'b1010, 4'b1001};
        logic [15:0] exp_cnt [6] = '{16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
        for (int i = 0; i < 6; i++) begin
            hold(pats[i], 20);
            checks++; if (stb_cnt !== 1 || dir !== 1'b0 || step_count !== exp_cnt[i]) begin errors++; $display("FAIL rev_step%0d: got stb=%0d dir=%b count=%h expected 1 0 %h", i, stb_cnt, dir, step_count, exp_cnt[i]); end
        end
        hold(4'b0101, 1);
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL glitch1_on: got %0d strobes expected 0", stb_cnt); end
        hold(4'b1001, 20);
        checks++; if (stb_cnt !== 0 || step_count !== 16'hFFFE) begin errors++; $display("FAIL glitch1: got stb=%0d count=%h expected 0 fffe", stb_cnt, step_count); end
        hold(4'b0101, 3);
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL glitch3_on: got %0d strobes expected 0", stb_cnt); end
        hold(4'b1001, 20);
        checks++; if (stb_cnt !== 0 || step_count !== 16'hFFFE || pos_idx !== 2'd2) begin errors++; $display("FAIL glitch3: got stb=%0d count=%h pos=%0d expected 0 fffe 2", stb_cnt, step_count, pos_idx); end
    endtask

    task automatic test_skip();
        hold(4'b0101, 20);
        hold(4'b0110, 20);
        checks++; if (step_count !== 16'hFFFC || pos_idx !== 2'd0) begin errors++; $display("FAIL skip_pre: got count=%h pos=%0d expected fffc 0", step_count, pos_idx); end
        hold(4'b1001, 20);
        checks++; if (stb_cnt !== 0 || fault !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL skip_fault: got stb=%0d fault=%b err=%b expected 0 1 10", stb_cnt, fault, err_code); end
        checks++; if (pos_idx !== 2'd2 || step_count !== 16'hFFFC) begin errors++; $display("FAIL skip_pos: got pos=%0d count=%h expected 2 fffc", pos_idx, step_count); end
        hold(4'b1111, 20);
        checks++; if (fault !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL skip_first_err: got fault=%b err=%b expected 1 10", fault, err_code); end
        hold(4'b1010, 20);
        checks++; if (stb_cnt !== 0 || pos_idx !== 2'd3 || step_count !== 16'hFFFC) begin errors++; $display("FAIL fault_track: got stb=%0d pos=%0d count=%h expected 0 3 fffc", stb_cnt, pos_idx, step_count); end
        pulse_clr();
        checks++; if (fault !== 1'b0 || err_code !== 2'b00 || step_count !== 16'h0000 || period !== 24'd0) begin errors++; $display("FAIL clr: got fault=%b err=%b count=%h period=%0d expected 0 00 0000 0", fault, err_code, step_count, period); end
        checks++; if (pos_idx !== 2'd3) begin errors++; $display("FAIL clr_pos_hold: got %0d expected 3", pos_idx); end
        hold(4'b1001, 20);
        checks++; if (stb_cnt !== 0 || pos_idx !== 2'd2) begin errors++; $display("FAIL clr_reacq: got stb=%0d pos=%0d expected 0 2", stb_cnt, pos_idx); end
        hold(4'b1010, 20);
        checks++; if (stb_cnt !== 1 || pvld_cnt !== 1 || step_count !== 16'h0001 || dir !== 1'b1) begin errors++; $display("FAIL clr_first_step: got stb=%0d pvld=%0d count=%h dir=%b expected 1 1 0001 1", stb_cnt, pvld_cnt, step_count, dir); end
    endtask

    task automatic test_invalid_and_zero();
        hold(4'b0111, 20);
        checks++; if (stb_cnt !== 0 || fault !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL invalid: got stb=%0d fault=%b err=%b expected 0 1 01", stb_cnt, fault, err_code); end
        pulse_clr();
        hold(4'b0110, 20);
        checks++; if (stb_cnt !== 0 || pos_idx !== 2'd0 || fault !== 1'b0) begin errors++; $display("FAIL inv_reacq: got stb=%0d pos=%0d fault=%b expected 0 0 0", stb_cnt, pos_idx, fault); end
        hold(4'b0000, 20);
        checks++; if (stb_cnt !== 0 || fault !== 1'b0 || pos_idx !== 2'd0) begin errors++; $display("FAIL zero_ignored: got stb=%0d fault=%b pos=%0d expected 0 0 0", stb_cnt, fault, pos_idx); end
        hold(4'b0101, 20);
        checks++; if (stb_cnt !== 1 || step_count !== 16'h0001 || pos_idx !== 2'd1 || fault !== 1'b0) begin errors++; $display("FAIL zero_resume: got stb=%0d count=%h pos=%0d fault=%b expected 1 0001 1 0", stb_cnt, step_count, pos_idx, fault); end
    endtask

    task automatic test_clr_vs_accept();
        int seen = 0;
        coil = 4'b1001;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) clr = 1'b1;
            @(negedge clk);
            if (step_stb) seen++;
        end
        clr = 1'b0;
        checks++; if (seen !== 0 || step_count !== 16'h0000) begin errors++; $display("FAIL clr_wins: got stb=%0d count=%h expected 0 0000", seen, step_count); end
        hold(4'b1001, 15);
        checks++; if (stb_cnt !== 0 || pos_idx !== 2'd1) begin errors++; $display("FAIL clr_discard: got stb=%0d pos=%0d expected 0 1", stb_cnt, pos_idx); end
        hold(4'b1010, 20);
        checks++; if (stb_cnt !== 0 || pos_idx !== 2'd3) begin errors++; $display("FAIL clr_new_acq: got stb=%0d pos=%0d expected 0 3", stb_cnt, pos_idx); end
        hold(4'b0110, 20);
        checks++; if (stb_cnt !== 1 || step_count !== 16'h0001) begin errors++; $display("FAIL clr_track: got stb=%0d count=%h expected 1 0001", stb_cnt, step_count); end
    endtask

    task automatic test_stall();
        int first_stall = 0;
        int stb_k = 0;
        logic stall_pre = 1'b0;
        logic stall_at_stb = 1'b1;
        logic pvld_at = 1'b0;
        logic [23:0] per_k = 24'd0;
        hold(4'b0101, 6);
        checks++; if (stb_at !== 6) begin errors++; $display("FAIL stall_start: got %0d expected 6", stb_at); end
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (stalled && first_stall == 0) first_stall = k;
            if (k == 149) stall_pre = stalled;
            if (step_stb && stb_k == 0) begin stb_k = k; stall_at_stb = stalled; per_k = period; pvld_at = period_vld; end
            if (k == 144) coil = 4'b1001;
        end
        checks++; if (first_stall !== 100) begin errors++; $display("FAIL stall_onset: got %0d expected 100", first_stall); end
        checks++; if (stall_pre !== 1'b1) begin errors++; $display("FAIL stall_held: got %b expected 1", stall_pre); end
        checks++; if (stb_k !== 150 || stall_at_stb !== 1'b0 || pvld_at !== 1'b1) begin errors++; $display("FAIL stall_clear: got at=%0d stalled=%b pvld=%b expected 150 0 1", stb_k, stall_at_stb, pvld_at); end
        checks++; if (per_k !== 24'd150) begin errors++; $display("FAIL stall_period: got %0d expected 150", per_k); end
        checks++; if (step_count !== 16'h0003 || pos_idx !== 2'd2) begin errors++; $display("FAIL stall_state: got count=%h pos=%0d expected 0003 2", step_count, pos_idx); end
    endtask

    task automatic test_reset_mid();
        coil = 4'b1010;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (step_count !== 16'h0000 || pos_idx !== 2'd0 || period !== 24'd0) begin errors++; $display("FAIL async_rst: got count=%h pos=%0d period=%0d expected 0000 0 0", step_count, pos_idx, period); end
        checks++; if ({dir, step_stb, stalled, fault, err_code} !== 6'b0) begin errors++; $display("FAIL async_rst_flags: got %b expected 000000", {dir, step_stb, stalled, fault, err_code}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(4'b1010, 20);
        checks++; if (stb_cnt !== 0 || pos_idx !== 2'd3 || step_count !== 16'h0000) begin errors++; $display("FAIL rst_reacq: got stb=%0d pos=%0d count=%h expected 0 3 0000", stb_cnt, pos_idx, step_count); end
        hold(4'b0110, 20);
        checks++; if (stb_cnt !== 1 || step_count !== 16'h0001 || pos_idx !== 2'd0) begin errors++; $display("FAIL rst_step: got stb=%0d count=%h pos=%0d expected 1 0001 0", stb_cnt, step_count, pos_idx); end
    endtask

    task automatic test_wrap();
        logic [3:0] pats [4] = '{4'b0110, 4'b0101, 4'b1001, 4'b1010};
        int total = 0;
        int first_at = 0;
        hold2(pats[0], 4);
        checks++; if (stb2_cnt !== 0 || pos2 !== 2'd0) begin errors++; $display("FAIL wrap_acq: got stb=%0d pos=%0d expected 0 0", stb2_cnt, pos2); end
        for (int s = 1; s <= 127; s++) begin
            hold2(pats[s % 4], 3);
            total += stb2_cnt;
            if (s == 1) first_at = stb2_at;
        end
        checks++; if (first_at !== 3) begin errors++; $display("FAIL filt1_latency: got %0d expected 3", first_at); end
        checks++; if (total !== 127 || count2 !== 8'h7F || period2 !== 24'd3) begin errors++; $display("FAIL wrap_pre: got steps=%0d count=%h period=%0d expected 127 7f 3", total, count2, period2); end
        hold2(pats[0], 3);
        checks++; if (count2 !== 8'h80 || dir2 !== 1'b1) begin errors++; $display("FAIL wrap_pos: got count=%h dir=%b expected 80 1", count2, dir2); end
        hold2(pats[3], 3);
        checks++; if (count2 !== 8'h7F || dir2 !== 1'b0) begin errors++; $display("FAIL wrap_neg: got count=%h dir=%b expected 7f 0", count2, dir2); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_skip();
        test_invalid_and_zero();
        test_clr_vs_accept();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
